// File: rtl/washer_cycle_timer_if.sv
`default_nettype none
// =============================================================================
// Module      : washer_cycle_timer_if
// Description : Control/status bundle between a washer cycle timer and its host.
// Revision    : 1.0 - initial release
// =============================================================================
interface washer_cycle_timer_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] fill_time;
    logic [WIDTH-1:0] wash_time;
    logic [WIDTH-1:0] rinse_time;
    logic [WIDTH-1:0] spin_time;
    logic [2:0]       phase;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             phase_done;
    logic             done;

    modport master (
        output start, pause, abort, fill_time, wash_time, rinse_time, spin_time,
        input  phase, remaining, busy, phase_done, done
    );

    modport slave (
        input  start, pause, abort, fill_time, wash_time, rinse_time, spin_time,
        output phase, remaining, busy, phase_done, done
    );
endinterface
`default_nettype wire

// File: rtl/washer_cycle_timer.sv
`default_nettype none
// =============================================================================
// Module      : washer_cycle_timer
// Description : Four-phase (fill/wash/rinse/spin) wash cycle sequencer with
//               prescaled tick, pause, abort and zero-duration phase skipping.
// Revision    : 1.0 - initial release
// =============================================================================
module washer_cycle_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    washer_cycle_timer_if.slave   ctl
);

    localparam logic [2:0] c_PH_IDLE  = 3'd0;
    localparam logic [2:0] c_PH_FILL  = 3'd1;
    localparam logic [2:0] c_PH_WASH  = 3'd2;
    localparam logic [2:0] c_PH_RINSE = 3'd3;
    localparam logic [2:0] c_PH_SPIN  = 3'd4;

    localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    logic [2:0]        r_phase;
    logic [WIDTH-1:0]  r_remaining;
    logic [c_PS_W-1:0] r_ps;
    logic              r_phase_done;
    logic              r_done;
    logic [WIDTH-1:0]  r_dur [4];

    logic [2:0]        w_phase_nxt;
    logic [WIDTH-1:0]  w_remaining_nxt;
    logic [c_PS_W-1:0] w_ps_nxt;
    logic              w_phase_done_nxt;
    logic              w_done_nxt;
    logic [WIDTH-1:0]  w_dur_nxt [4];
    logic [2:0]        w_first;
    logic              w_tick;
    logic [3:0]        w_in_nz;
    logic [3:0]        w_lat_nz;

    // Lowest-numbered phase strictly after cur whose duration is nonzero; IDLE if none.
    function automatic logic [2:0] f_first_after(input logic [2:0] cur, input logic [3:0] nz);
        logic [2:0] res;
        res = c_PH_IDLE;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) + 3'd1) > cur && nz[i]) begin
                res = 3'(i) + 3'd1;
            end
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] f_dur_of(
        input logic [2:0]       ph,
        input logic [WIDTH-1:0] d_fill,
        input logic [WIDTH-1:0] d_wash,
        input logic [WIDTH-1:0] d_rinse,
        input logic [WIDTH-1:0] d_spin
    );
        logic [WIDTH-1:0] res;
        case (ph)
            c_PH_FILL:  res = d_fill;
            c_PH_WASH:  res = d_wash;
            c_PH_RINSE: res = d_rinse;
            c_PH_SPIN:  res = d_spin;
            default:    res = '0;
        endcase
        return res;
    endfunction

    assign w_tick   = (r_ps == c_PS_LAST);
    assign w_in_nz  = {ctl.spin_time != '0, ctl.rinse_time != '0,
                       ctl.wash_time != '0, ctl.fill_time != '0};
    assign w_lat_nz = {r_dur[3] != '0, r_dur[2] != '0, r_dur[1] != '0, r_dur[0] != '0};

    always_comb begin
        w_phase_nxt      = r_phase;
        w_remaining_nxt  = r_remaining;
        w_ps_nxt         = r_ps;
        w_phase_done_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_first          = c_PH_IDLE;
        for (int i = 0; i < 4; i++) begin
            w_dur_nxt[i] = r_dur[i];
        end

        if (ctl.abort) begin
            w_phase_nxt     = c_PH_IDLE;
            w_remaining_nxt = '0;
            w_ps_nxt        = '0;
        end else if (r_phase == c_PH_IDLE) begin
            if (ctl.start) begin
                w_dur_nxt[0]    = ctl.fill_time;
                w_dur_nxt[1]    = ctl.wash_time;
                w_dur_nxt[2]    = ctl.rinse_time;
                w_dur_nxt[3]    = ctl.spin_time;
                w_ps_nxt        = '0;
                // Durations are taken from the inputs here since the latch lands on this same edge.
                w_first         = f_first_after(c_PH_IDLE, w_in_nz);
                w_phase_nxt     = w_first;
                w_remaining_nxt = f_dur_of(w_first, ctl.fill_time, ctl.wash_time,
                                           ctl.rinse_time, ctl.spin_time);
                w_done_nxt      = (w_first == c_PH_IDLE);
            end
        end else if (!ctl.pause) begin
            w_ps_nxt = w_tick ? '0 : r_ps + c_PS_W'(1);
            if (w_tick) begin
                if (r_remaining > WIDTH'(1)) begin
                    w_remaining_nxt = r_remaining - WIDTH'(1);
                end else begin
                    w_first          = f_first_after(r_phase, w_lat_nz);
                    w_phase_nxt      = w_first;
                    w_remaining_nxt  = f_dur_of(w_first, r_dur[0], r_dur[1], r_dur[2], r_dur[3]);
                    w_phase_done_nxt = 1'b1;
                    w_done_nxt       = (w_first == c_PH_IDLE);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase      <= c_PH_IDLE;
            r_remaining  <= '0;
            r_ps         <= '0;
            r_phase_done <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_dur[i] <= '0;
            end
        end else begin
            r_phase      <= w_phase_nxt;
            r_remaining  <= w_remaining_nxt;
            r_ps         <= w_ps_nxt;
            r_phase_done <= w_phase_done_nxt;
            r_done       <= w_done_nxt;
            for (int i = 0; i < 4; i++) begin
                r_dur[i] <= w_dur_nxt[i];
            end
        end
    end

    assign ctl.phase      = r_phase;
    assign ctl.remaining  = r_remaining;
    assign ctl.busy       = (r_phase != c_PH_IDLE);
    assign ctl.phase_done = r_phase_done;
    assign ctl.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_washer_cycle_timer.sv
`default_nettype none
// =============================================================================
// Module      : tb_washer_cycle_timer
// Description : Directed self-checking bench; PRESCALE=1 and PRESCALE=3 instances
//               share stimulus, one is observed per test.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_washer_cycle_timer;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       pause;
    logic       abort;
    logic [7:0] d_fill;
    logic [7:0] d_wash;
    logic [7:0] d_rinse;
    logic [7:0] d_spin;
    logic       sel3;

    int n_checks;
    int n_fail;

    logic [2:0] ph [32];
    logic [7:0] rm [32];
    logic       pd [32];
    logic       dn [32];
    logic       bz [32];
    int         exp_ph [9];
    int         cnt;
    int         idx;

    washer_cycle_timer_if #(.WIDTH(8)) b1 ();
    washer_cycle_timer_if #(.WIDTH(8)) b3 ();

    assign b1.start = start;      assign b3.start = start;
    assign b1.pause = pause;      assign b3.pause = pause;
    assign b1.abort = abort;      assign b3.abort = abort;
    assign b1.fill_time  = d_fill;  assign b3.fill_time  = d_fill;
    assign b1.wash_time  = d_wash;  assign b3.wash_time  = d_wash;
    assign b1.rinse_time = d_rinse; assign b3.rinse_time = d_rinse;
    assign b1.spin_time  = d_spin;  assign b3.spin_time  = d_spin;

    washer_cycle_timer #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (b1.slave)
    );

    washer_cycle_timer #(.WIDTH(8), .PRESCALE(3)) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int f, input int w, input int r, input int s);
        d_fill  = 8'(f);
        d_wash  = 8'(w);
        d_rinse = 8'(r);
        d_spin  = 8'(s);
    endtask

    task automatic clear_both();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    // Index k holds the outputs seen after the k-th edge counting the start edge as 0.
    task automatic run(input int ncyc, input int inject_at, input int pause_at,
                       input int pause_len, input int abort_at);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            ph[k] = sel3 ? b3.phase      : b1.phase;
            rm[k] = sel3 ? b3.remaining  : b1.remaining;
            pd[k] = sel3 ? b3.phase_done : b1.phase_done;
            dn[k] = sel3 ? b3.done       : b1.done;
            bz[k] = sel3 ? b3.busy       : b1.busy;
            if (k == inject_at) begin
                start = 1'b1;
                set_dur(7, 7, 7, 7);
            end else if (k == inject_at + 1) begin
                start = 1'b0;
            end
            if (k == pause_at) pause = 1'b1;
            if (k == pause_at + pause_len) pause = 1'b0;
            if (k == abort_at) abort = 1'b1;
            else if (k == abort_at + 1) abort = 1'b0;
            if (k < ncyc - 1) step();
        end
    endtask

    task automatic check_full_cycle(input string tag);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_ph%0d", tag, k), 32'(ph[k]), 32'(exp_ph[k]));
        end
        cnt = 0;
        idx = -1;
        for (int k = 0; k < 9; k++) begin
            if (pd[k]) cnt++;
            if (dn[k]) idx = k;
        end
        check({tag, "_pd_count"}, 32'(cnt), 32'd4);
        check({tag, "_done_at"}, 32'(idx), 32'd8);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel3  = 1'b0;
        rstn  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        set_dur(0, 0, 0, 0);
        exp_ph = '{1, 1, 2, 2, 2, 3, 4, 4, 0};

        #12;
        check("rst_phase", 32'(b1.phase), 32'd0);
        check("rst_rem", 32'(b1.remaining), 32'd0);
        check("rst_busy", 32'(b1.busy), 32'd0);
        check("rst_flags", 32'({b1.done, b1.phase_done}), 32'd0);
        rstn = 1'b1;
        step();

        // Full cycle 2/3/1/2
        set_dur(2, 3, 1, 2);
        run(9, -1, -1, 0, -1);
        check_full_cycle("full");
        check("full_rem0", 32'(rm[0]), 32'd2);
        check("full_rem1", 32'(rm[1]), 32'd1);
        check("full_rem2", 32'(rm[2]), 32'd3);
        check("full_rem8", 32'(rm[8]), 32'd0);

        // Skipped phases 0/4/0/0
        clear_both();
        set_dur(0, 4, 0, 0);
        run(6, -1, -1, 0, -1);
        check("skip_ph0", 32'(ph[0]), 32'd2);
        check("skip_rem0", 32'(rm[0]), 32'd4);
        check("skip_ph3", 32'(ph[3]), 32'd2);
        check("skip_ph4", 32'(ph[4]), 32'd0);
        check("skip_done4", 32'({dn[4], pd[4]}), 32'd3);
        check("skip_done3", 32'(dn[3]), 32'd0);

        // All zero durations
        clear_both();
        set_dur(0, 0, 0, 0);
        run(3, -1, -1, 0, -1);
        check("zero_done0", 32'(dn[0]), 32'd1);
        check("zero_done1", 32'(dn[1]), 32'd0);
        check("zero_busy", 32'({bz[0], bz[1], bz[2]}), 32'd0);
        check("zero_pd", 32'({pd[0], pd[1], pd[2]}), 32'd0);

        // Prescale 3 with a 5-cycle pause mid-FILL
        clear_both();
        sel3 = 1'b1;
        set_dur(2, 0, 0, 0);
        run(13, -1, 3, 5, -1);
        check("ps_rem2", 32'(rm[2]), 32'd2);
        check("ps_rem3", 32'(rm[3]), 32'd1);
        check("ps_rem_paused", 32'(rm[8]), 32'd1);
        check("ps_pd_paused", 32'({pd[4], pd[5], pd[6], pd[7], pd[8]}), 32'd0);
        check("ps_ph10", 32'(ph[10]), 32'd1);
        check("ps_ph11", 32'(ph[11]), 32'd0);
        check("ps_done11", 32'({dn[11], pd[11]}), 32'd3);
        check("ps_done10", 32'(dn[10]), 32'd0);
        sel3 = 1'b0;

        // Abort in WASH with remaining 2
        clear_both();
        set_dur(2, 3, 1, 2);
        run(6, -1, -1, 0, 3);
        check("ab_ph3", 32'(ph[3]), 32'd2);
        check("ab_rem3", 32'(rm[3]), 32'd2);
        check("ab_ph4", 32'(ph[4]), 32'd0);
        check("ab_rem4", 32'(rm[4]), 32'd0);
        check("ab_flags", 32'({dn[4], pd[4], dn[5], pd[5]}), 32'd0);
        run(9, -1, -1, 0, -1);
        check_full_cycle("after_ab");

        // Start and new durations injected mid-RINSE
        clear_both();
        set_dur(2, 3, 1, 2);
        run(9, 5, -1, 0, -1);
        check_full_cycle("inject");
        check("inject_rem6", 32'(rm[6]), 32'd2);

        // Abort together with start from IDLE
        clear_both();
        set_dur(2, 3, 1, 2);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abst_ph", 32'(b1.phase), 32'd0);
        check("abst_done", 32'(b1.done), 32'd0);

        // Asynchronous reset mid-SPIN, then start on the first edge
        clear_both();
        set_dur(2, 3, 1, 2);
        run(7, -1, -1, 0, -1);
        check("rs_ph6", 32'(ph[6]), 32'd4);
        #2;
        rstn = 1'b0;
        #1;
        check("rs_ph", 32'(b1.phase), 32'd0);
        check("rs_rem", 32'(b1.remaining), 32'd0);
        check("rs_busy", 32'(b1.busy), 32'd0);
        rstn  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_start_ph", 32'(b1.phase), 32'd1);
        check("rs_start_rem", 32'(b1.remaining), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
